// File: rtl/invader_fire_scheduler.sv
// Picks a round-robin live shooter and the lowest free projectile slot after a tick-counted cooldown.
// Offer registered one cycle after PICK; held stable under fire_ready=0 until transfer; play=0 aborts.
module invader_fire_scheduler #(
    parameter int NSHOOT   = 5,
    parameter int SPACING  = 40,
    parameter int COOLDOWN = 8,
    parameter int NSLOT    = 2,
    localparam int IW = (NSHOOT > 1) ? $clog2(NSHOOT) : 1,
    localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1,
    localparam int CW = $clog2(COOLDOWN + 1)
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              play,
    input  logic              tick,
    input  logic [NSHOOT-1:0] alive,
    input  logic [NSLOT-1:0]  slot_busy,
    input  logic [9:0]        formation_x,
    input  logic [9:0]        formation_y,
    input  logic              fire_ready,
    output logic              fire_valid,
    output logic [SW-1:0]     fire_slot,
    output logic [IW-1:0]     fire_idx,
    output logic [9:0]        fire_x,
    output logic [9:0]        fire_y,
    output logic [7:0]        shots_fired
);

    typedef enum logic [1:0] {IDLE, COOL, PICK, OFFER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] last_idx;

    logic          shooter_found;
    logic [IW-1:0] pick_idx;
    logic          slot_found;
    logic [SW-1:0] pick_slot;
    int            cand;
    logic [31:0]   x_sum;

    // Descending scans so the nearest candidate (after last_idx / lowest slot) is written last.
    always_comb begin
        shooter_found = 1'b0;
        pick_idx      = '0;
        cand          = 0;
        for (int k = NSHOOT; k >= 1; k--) begin
            cand = (int'(last_idx) + k) % NSHOOT;
            if (alive[cand[IW-1:0]]) begin
                shooter_found = 1'b1;
                pick_idx      = cand[IW-1:0];
            end
        end
        slot_found = 1'b0;
        pick_slot  = '0;
        for (int j = NSLOT - 1; j >= 0; j--) begin
            if (!slot_busy[j]) begin
                slot_found = 1'b1;
                pick_slot  = SW'(j);
            end
        end
        x_sum = 32'(formation_x) + 32'(SPACING) * 32'(pick_idx);
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            last_idx    <= IW'(NSHOOT - 1);
            fire_valid  <= 1'b0;
            fire_slot   <= '0;
            fire_idx    <= '0;
            fire_x      <= '0;
            fire_y      <= '0;
            shots_fired <= '0;
        end else begin
            // A handshake still counts on the same cycle that play drops.
            if (state == OFFER && fire_ready) begin
                last_idx <= fire_idx;
                if (shots_fired != 8'hFF)
                    shots_fired <= shots_fired + 8'd1;
            end
            if (!play) begin
                state      <= IDLE;
                fire_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= COOL;
                        cnt   <= CW'(COOLDOWN);
                    end
                    COOL: begin
                        if (tick) begin
                            if (cnt <= CW'(1)) begin
                                cnt   <= '0;
                                state <= PICK;
                            end else begin
                                cnt <= cnt - CW'(1);
                            end
                        end
                    end
                    PICK: begin
                        if (shooter_found && slot_found) begin
                            fire_idx   <= pick_idx;
                            fire_slot  <= pick_slot;
                            fire_x     <= x_sum[9:0];
                            fire_y     <= formation_y + 10'd20;
                            fire_valid <= 1'b1;
                            state      <= OFFER;
                        end
                    end
                    OFFER: begin
                        if (fire_ready) begin
                            fire_valid <= 1'b0;
                            cnt        <= CW'(COOLDOWN);
                            state      <= COOL;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_invader_fire_scheduler.sv
// Directed plus randomized checks of invader_fire_scheduler against a phase-level reference model.
module tb_invader_fire_scheduler;
    localparam int NSHOOT = 5, SPACING = 40, COOLDOWN = 8, NSLOT = 2;

    logic       dclk = 1'b0;
    logic       clr = 1'b0, play = 1'b0, tick = 1'b0, fire_ready = 1'b0;
    logic [4:0] alive = '0;
    logic [1:0] slot_busy = '0;
    logic [9:0] formation_x = '0, formation_y = '0;
    logic       fire_valid;
    logic [0:0] fire_slot;
    logic [2:0] fire_idx;
    logic [9:0] fire_x, fire_y;
    logic [7:0] shots_fired;

    invader_fire_scheduler #(.NSHOOT(NSHOOT), .SPACING(SPACING), .COOLDOWN(COOLDOWN), .NSLOT(NSLOT)) dut (
        .dclk(dclk), .clr(clr), .play(play), .tick(tick), .alive(alive), .slot_busy(slot_busy),
        .formation_x(formation_x), .formation_y(formation_y), .fire_ready(fire_ready),
        .fire_valid(fire_valid), .fire_slot(fire_slot), .fire_idx(fire_idx),
        .fire_x(fire_x), .fire_y(fire_y), .shots_fired(shots_fired)
    );

    always #5 dclk = ~dclk;

    int n_cmp = 0, n_bad = 0;

    // Model: running flag, ticks still owed, and whether an offer is outstanding.
    bit m_run = 0;
    int m_ticks = 0, m_last = NSHOOT - 1;
    int e_vld = 0, e_idx = 0, e_slot = 0, e_x = 0, e_y = 0, e_shots = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        bit xfer;
        int order[$];
        int free_slot;
        if (clr) begin
            m_run = 0; m_ticks = 0; m_last = NSHOOT - 1;
            e_vld = 0; e_idx = 0; e_slot = 0; e_x = 0; e_y = 0; e_shots = 0;
            return;
        end
        xfer = (e_vld == 1) && fire_ready;
        if (xfer) begin
            m_last = e_idx;
            if (e_shots < 255) e_shots++;
        end
        if (!play) begin
            m_run = 0; e_vld = 0;
        end else if (!m_run) begin
            m_run = 1; m_ticks = COOLDOWN;
        end else if (e_vld == 1) begin
            if (xfer) begin e_vld = 0; m_ticks = COOLDOWN; end
        end else if (m_ticks > 0) begin
            if (tick) m_ticks--;
        end else begin
            for (int k = 1; k <= NSHOOT; k++)
                if (alive[(m_last + k) % NSHOOT]) order.push_back((m_last + k) % NSHOOT);
            free_slot = -1;
            for (int j = NSLOT - 1; j >= 0; j--) if (!slot_busy[j]) free_slot = j;
            if (order.size() > 0 && free_slot >= 0) begin
                e_vld = 1; e_idx = order[0]; e_slot = free_slot;
                e_x = (int'(formation_x) + SPACING * order[0]) % 1024;
                e_y = (int'(formation_y) + 20) % 1024;
            end
        end
    endfunction

    task automatic step();
        @(posedge dclk);
        model_edge();
        #1;
        chk("valid", 32'(fire_valid), 32'(e_vld));
        chk("idx", 32'(fire_idx), 32'(e_idx));
        chk("slot", 32'(fire_slot), 32'(e_slot));
        chk("x", 32'(fire_x), 32'(e_x));
        chk("y", 32'(fire_y), 32'(e_y));
        chk("shots", 32'(shots_fired), 32'(e_shots));
    endtask

    task automatic restart();
        clr = 1; play = 0; tick = 0; step(); clr = 0;
    endtask

    task automatic wait_valid(input int bound, output int steps);
        steps = 0;
        while (!fire_valid && steps < bound) begin tick = ~tick; step(); steps++; end
        tick = 0;
        chk("wait_valid_timeout", 32'(fire_valid), 32'd1);
    endtask

    int got_idx[$], got_x[$], got_slot[$];
    int first_ticks;

    task automatic run_offers(input int n);
        int cyc = 0, ticks = 0;
        got_idx.delete(); got_x.delete(); got_slot.delete();
        first_ticks = -1;
        while (got_idx.size() < n && cyc < 60 * n) begin
            tick = (cyc % 4 == 3);
            if (tick) ticks++;
            step(); cyc++;
            if (fire_valid && first_ticks < 0) first_ticks = ticks;
            if (fire_valid && fire_ready) begin
                got_idx.push_back(int'(fire_idx)); got_x.push_back(int'(fire_x));
                got_slot.push_back(int'(fire_slot));
            end
        end
        tick = 0;
        chk("run_offers_count", 32'(got_idx.size()), 32'(n));
    endtask

    initial begin
        int s, snap_idx, snap_x, snap_y, snap_slot, snap_shots;
        int exp_idx1[6] = '{0, 1, 2, 3, 4, 0};
        int exp_x1[6]   = '{100, 140, 180, 220, 260, 100};

        restart();
        chk("reset_valid", 32'(fire_valid), 32'd0);
        chk("reset_shots", 32'(shots_fired), 32'd0);

        // Basic round-robin offers
        alive = 5'b11111; slot_busy = 0; formation_x = 100; formation_y = 50; fire_ready = 1;
        play = 1; step();
        run_offers(6);
        chk("first_offer_ticks", 32'(first_ticks), 32'd8);
        for (int k = 0; k < got_idx.size() && k < 6; k++) begin
            chk("rr_idx", 32'(got_idx[k]), 32'(exp_idx1[k]));
            chk("rr_x", 32'(got_x[k]), 32'(exp_x1[k]));
            chk("rr_slot", 32'(got_slot[k]), 32'd0);
        end

        // Dead-shooter skip, slot 0 busy
        restart();
        alive = 5'b10010; slot_busy = 2'b01; play = 1; step();
        run_offers(4);
        for (int k = 0; k < got_idx.size() && k < 4; k++) begin
            chk("skip_idx", 32'(got_idx[k]), (k % 2 == 0) ? 32'd1 : 32'd4);
            chk("skip_x", 32'(got_x[k]), (k % 2 == 0) ? 32'd140 : 32'd260);
            chk("skip_slot", 32'(got_slot[k]), 32'd1);
        end

        // Backpressure with moving formation
        restart();
        alive = 5'b11111; slot_busy = 0; formation_x = 100; formation_y = 50; fire_ready = 0; play = 1;
        step(); wait_valid(100, s);
        snap_idx = int'(fire_idx); snap_x = int'(fire_x); snap_y = int'(fire_y);
        snap_slot = int'(fire_slot); snap_shots = int'(shots_fired);
        chk("bp_offer_x", 32'(snap_x), 32'd100);
        chk("bp_offer_y", 32'(snap_y), 32'd70);
        for (int k = 0; k < 20; k++) begin
            formation_x = 10'($urandom); formation_y = 10'($urandom);
            alive = 5'($urandom); slot_busy = 2'($urandom); tick = 1'($urandom);
            step();
            chk("bp_hold_valid", 32'(fire_valid), 32'd1);
            chk("bp_hold_idx", 32'(fire_idx), 32'(snap_idx));
            chk("bp_hold_slot", 32'(fire_slot), 32'(snap_slot));
            chk("bp_hold_x", 32'(fire_x), 32'(snap_x));
            chk("bp_hold_y", 32'(fire_y), 32'(snap_y));
            chk("bp_hold_shots", 32'(shots_fired), 32'(snap_shots));
        end
        tick = 0; fire_ready = 1; step();
        chk("bp_shots_inc", 32'(shots_fired), 32'(snap_shots + 1));
        chk("bp_valid_drop", 32'(fire_valid), 32'd0);
        step(); step();
        clr = 1; step(); clr = 0;
        chk("clr_valid", 32'(fire_valid), 32'd0);
        chk("clr_idx", 32'(fire_idx), 32'd0);
        chk("clr_slot", 32'(fire_slot), 32'd0);
        chk("clr_x", 32'(fire_x), 32'd0);
        chk("clr_y", 32'(fire_y), 32'd0);
        chk("clr_shots", 32'(shots_fired), 32'd0);

        // Starvation: no live shooter, then no free slot
        alive = 0; slot_busy = 0; fire_ready = 1; formation_x = 100; play = 1;
        for (int k = 0; k < 30; k++) begin
            tick = 1; step(); chk("starve_alive", 32'(fire_valid), 32'd0);
        end
        alive = 5'b11111; slot_busy = 2'b11;
        for (int k = 0; k < 10; k++) begin
            step(); chk("starve_slot", 32'(fire_valid), 32'd0);
        end
        tick = 0; slot_busy = 2'b10;
        s = 0;
        while (!fire_valid && s < 2) begin step(); s++; end
        chk("unstarve_valid", 32'(fire_valid), 32'd1);
        chk("unstarve_slot", 32'(fire_slot), 32'd0);

        // Abort during OFFER, then full cooldown from IDLE
        fire_ready = 0; slot_busy = 0; step();
        snap_shots = int'(shots_fired);
        play = 0; step();
        chk("abort_valid", 32'(fire_valid), 32'd0);
        chk("abort_shots", 32'(shots_fired), 32'(snap_shots));
        play = 1; tick = 1; s = 0;
        while (!fire_valid && s < 40) begin step(); s++; end
        tick = 0;
        chk("abort_restart_cycles", 32'(s), 32'd10);

        // fire_x wraps at 10 bits
        restart();
        alive = 5'b00010; slot_busy = 0; formation_x = 1000; fire_ready = 1; play = 1;
        step(); wait_valid(100, s);
        chk("wrap_idx", 32'(fire_idx), 32'd1);
        chk("wrap_x", 32'(fire_x), 32'd16);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            clr = ($urandom_range(199) == 0);
            play = ($urandom_range(49) != 0);
            tick = ($urandom_range(2) == 0);
            alive = ($urandom_range(3) == 0) ? 5'($urandom) : 5'b11111;
            slot_busy = 2'($urandom);
            formation_x = 10'($urandom); formation_y = 10'($urandom);
            fire_ready = 1'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
